// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with a one-cycle fast path for
// divide-by-zero and signed-overflow divides.
//
// Handshake: the controller raises start_i and holds it for the whole
// instruction. The unit answers with a single-cycle done_o pulse and
// result_o is valid in that cycle. Dropping start_i mid-operation aborts
// without a done_o pulse. Operands are sampled only in the IDLE cycle
// where start_i is first seen high.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  done_o,
  output logic                  busy_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [W-1:0]  MIN_VAL  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  ONES     = {W{1'b1}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [2:0]     op_q;
  logic [W-1:0]   opnd_q;   // |a| for multiply (addend), |b| for divide (divisor)
  logic [2*W-1:0] acc;      // {high, low} product or {remainder, quotient}
  logic           neg_res;  // product / quotient sign
  logic           neg_rem;  // remainder sign

  logic           a_signed, b_signed, sa, sb;
  logic [W-1:0]   a_mag, b_mag;
  logic           div_zero, div_ovf, special;
  logic [W-1:0]   special_res;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shift, div_diff;
  logic           div_ge;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem;
  logic [W-1:0]   mul_res, div_res;

  // Operand decode: signedness, magnitudes and divide special cases.
  always_comb begin
    a_signed = (op_i == 3'd0) || (op_i == 3'd1) || (op_i == 3'd2) ||
               (op_i == 3'd4) || (op_i == 3'd6);
    b_signed = (op_i == 3'd0) || (op_i == 3'd1) || (op_i == 3'd4) ||
               (op_i == 3'd6);
    sa       = a_signed & operand_a_i[W-1];
    sb       = b_signed & operand_b_i[W-1];
    a_mag    = sa ? (~operand_a_i + 1'b1) : operand_a_i;
    b_mag    = sb ? (~operand_b_i + 1'b1) : operand_b_i;
    div_zero = op_i[2] && (operand_b_i == '0);
    div_ovf  = ((op_i == 3'd4) || (op_i == 3'd6)) &&
               (operand_a_i == MIN_VAL) && (operand_b_i == ONES);
    special  = div_zero || div_ovf;
    // op bit 1 selects REM/REMU among the divide ops
    if (op_i[1]) special_res = div_zero ? operand_a_i : '0;
    else         special_res = div_zero ? ONES : MIN_VAL;
  end

  // One iteration step of each datapath plus final sign correction.
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    mul_next  = {mul_sum, acc[W-1:1]};
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[W];
    div_next  = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc[W-2:0], div_ge};
    prod      = neg_res ? (~mul_next + 1'b1) : mul_next;
    mul_res   = (op_q == 3'd0) ? prod[W-1:0] : prod[2*W-1:W];
    quo       = div_next[W-1:0];
    rem       = div_next[2*W-1:W];
    if (op_q[1]) div_res = neg_rem ? (~rem + 1'b1) : rem;
    else         div_res = neg_res ? (~quo + 1'b1) : quo;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      acc      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            op_q    <= op_i;
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            cnt     <= '0;
            if (special) begin
              result_o <= special_res;
              state    <= ST_DONE;
            end else if (op_i[2]) begin
              opnd_q <= b_mag;
              acc    <= {{W{1'b0}}, a_mag};
              state  <= ST_DIV;
            end else begin
              opnd_q <= a_mag;
              acc    <= {{W{1'b0}}, b_mag};
              state  <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          if (!start_i) begin
            state <= ST_IDLE;
          end else begin
            acc <= mul_next;
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
              result_o <= mul_res;
              state    <= ST_DONE;
            end
          end
        end
        ST_DIV: begin
          if (!start_i) begin
            state <= ST_IDLE;
          end else begin
            acc <= div_next;
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
              result_o <= div_res;
              state    <= ST_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign done_o = (state == ST_DONE);
  assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a vector table of single operations
// followed by hand-written reset, back-to-back and abort sequences.
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic [31:0] result_o;
  logic        done_o;
  logic        busy_o;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  mul_div_unit #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .result_o    (result_o),
    .done_o      (done_o),
    .busy_o      (busy_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at a sample point (posedge+1). Counts cycles until done_o,
  // scrambling the operands after they have been sampled.
  task automatic wait_done(input string name, input int exp_lat, input int exp_busy,
                           input logic [31:0] exp_res);
    int  n = 0;
    int  busy_cnt = 0;
    bit  seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (busy_o) busy_cnt++;
      if (n == 2) begin
        op_i        = 3'($urandom_range(0, 7));
        operand_a_i = $urandom;
        operand_b_i = $urandom;
      end
      if (done_o) seen = 1;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({name, "_result"}, result_o, exp_res);
  endtask

  // Drops start after the done cycle and checks the pulse ended.
  task automatic finish_op(input string name, input logic [31:0] exp_res);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_done_pulse_end"}, 32'(done_o), 32'd0);
    check({name, "_idle_after"}, 32'(busy_o), 32'd0);
    check({name, "_result_held"}, result_o, exp_res);
  endtask

  initial begin
    int dones;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{3'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33};
    vecs[13] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[14] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[15] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 33};
    vecs[16] = '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33};
    vecs[17] = '{3'd7, 32'd9,         32'd0,         32'd9,         1};

    // Reset
    rst_n = 1'b0;
    start_i = 1'b0;
    op_i = 3'd0;
    operand_a_i = '0;
    operand_b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result_o, 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table
    for (int i = 0; i < 18; i++) begin
      op_i        = vecs[i].op;
      operand_a_i = vecs[i].a;
      operand_b_i = vecs[i].b;
      start_i     = 1'b1;
      wait_done($sformatf("vec%0d", i), vecs[i].lat, vecs[i].lat, vecs[i].exp);
      finish_op($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset in the middle of a multiply, start held across reset
    op_i = 3'd0; operand_a_i = 32'd7; operand_b_i = 32'd9; start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_result", result_o, 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    op_i = 3'd0; operand_a_i = 32'd5; operand_b_i = 32'd5;
    wait_done("midrst_restart", 33, 33, 32'd25);
    finish_op("midrst_restart", 32'd25);

    // Back-to-back multiplies with start held continuously
    op_i = 3'd0; operand_a_i = 32'd3; operand_b_i = 32'd4; start_i = 1'b1;
    wait_done("b2b_first", 33, 33, 32'd12);
    op_i = 3'd0; operand_a_i = 32'd5; operand_b_i = 32'd6;
    wait_done("b2b_second", 34, 33, 32'd30);
    finish_op("b2b_second", 32'd30);

    // Abort at cycle 5
    op_i = 3'd0; operand_a_i = 32'd9; operand_b_i = 32'd9; start_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    start_i = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done_o) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_result_held", result_o, 32'd30);
    check("abort_idle", 32'(busy_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Responder side of the core controller's multi-cycle handshake: the controller holds mm_start high and stalls until mm_done is seen.
- Sits beside the ALU in the execute stage and shares its operand buses.
- Radix-2: one bit per cycle, fast path for divide special cases.

Parameters:
- DATA_WIDTH, 32, operand/result width; counter is clog2(DATA_WIDTH) bits.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  mm_start from decoder; level, held high for the whole instruction
- op_i  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- operand_a_i  input  DATA_WIDTH  rs1 value
- operand_b_i  input  DATA_WIDTH  rs2 value
- result_o  output  DATA_WIDTH  registered result, valid while done_o high
- done_o  output  1  mm_done to controller; single-cycle pulse
- busy_o  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset, async at any time including mid-operation:
  - state=IDLE; result_o=0; done_o=0; busy_o=0; counter and all datapath regs cleared.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - Cycle 0 is the first cycle with start_i=1.
  - At its closing edge, latch op, |a|, |b| (magnitude only for signed-interpreted operands) and the result sign; clear counter.
  - Next state: MUL for op<4, DIV for op>=4.
  - Special cases go directly to DONE:
    - b==0: DIV/DIVU give all-ones; REM/REMU give a.
    - Signed overflow (op 4 or 6, a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV and REM: signed.
- MUL: shift-add on a 2*DATA_WIDTH accumulator, one multiplier bit per cycle, DATA_WIDTH cycles (counter 0..31).
- DIV: restoring division, one quotient bit per cycle, DATA_WIDTH cycles.
- Leaving MUL/DIV when counter==DATA_WIDTH-1:
  - Apply sign correction (two's-complement negate).
  - Product sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sa.
  - Select the result: MUL takes the low word; MULH/MULHSU/MULHU take the high word.
  - Load result_o and enter DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE unconditionally. start_i is ignored in DONE.
- Latency:
  - Normal op: done_o high in cycle DATA_WIDTH+1, i.e. cycle 33.
  - Special-case divide: done_o high in cycle 1.
- Back-to-back: if start_i is still high in the cycle after DONE (next instruction is also M-extension), that cycle is a new cycle 0 and operands are resampled. No idle gap is required beyond the DONE cycle.
- Abort: start_i=0 while in MUL or DIV returns to IDLE at the next edge. No done_o; result_o is unchanged.
- result_o holds its last value until the next DONE entry. done_o is never high outside DONE.
- op_i and operands may change after cycle 0 without effect.

Test Plan:
- Reset mid-MUL at cycle 10 (rst_n low 1 cycle) -> done_o, busy_o, result_o all 0 immediately; start_i held -> new op samples, done_o at cycle 33 after release.
- MUL 7 x 0xFFFFFFFD -> result_o=0xFFFFFFEB, done_o pulse exactly in cycle 33, busy_o high cycles 1..33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with done_o in cycle 1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM same -> 0, done_o in cycle 1.
- Two MULs with start_i held continuously (3x4 then 5x6) -> done pulses in cycles 33 and 67, results 12 then 30; start_i dropped at cycle 5 -> no done_o, result_o unchanged.
